rr_grant_index_8: RTL and testbench

- Round-robin arbiter over 8 requesters. Produces a registered 3-bit grant index plus a valid flag.
- Sits directly upstream of the 3-to-8 decoder, which turns grant_idx into the one-hot per-requester grant enables.
- Grants are held until the holder releases, drops its request, or exceeds a hold budget while others wait.

---
 rtl/rr_grant_index_8.sv | 125 ++++++++++++
 tb/tb_rr_grant_index_8.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_index_8.sv
// Round-robin arbiter over 8 requesters with registered grant index, valid and new-grant pulse.
// Optional ARB_LOCK_EN adds a lock input; the holder's release pulse is named release_grant since release is a reserved word.
module rr_grant_index_8 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  input  logic       release_grant,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       grant_new
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, next_state;
  logic [2:0]       ptr, next_ptr;
  logic [CNT_W-1:0] hold_cnt, next_cnt;
  logic [2:0]       next_idx;
  logic             next_valid, next_new;

  logic [2:0] base, scan, winner;
  logic       found;
  logic       holder_req, others_req, timeout, end_grant;

  // In GRANT the scan only matters on end-of-grant, where the old holder drops to lowest priority.
  always_comb begin
    base   = (state == GRANT) ? grant_idx + 3'd1 : ptr;
    winner = '0;
    found  = 1'b0;
    scan   = '0;
    for (int i = 0; i < 8; i++) begin
      scan = base + 3'(i);
      if (!found && req[scan]) begin
        winner = scan;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    holder_req = req[grant_idx];
    others_req = (req & ~(8'b1 << grant_idx)) != 8'b0;
    timeout    = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD)) && others_req;
`ifdef ARB_LOCK_EN
    end_grant  = release_grant || (!lock && (!holder_req || timeout));
`else
    end_grant  = release_grant || !holder_req || timeout;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      grant_new   <= 1'b0;
    end else begin
      state       <= next_state;
      ptr         <= next_ptr;
      hold_cnt    <= next_cnt;
      grant_idx   <= next_idx;
      grant_valid <= next_valid;
      grant_new   <= next_new;
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_cnt   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          next_state = GRANT;
          next_cnt   = '0;
        end
      end
      GRANT: begin
        if (end_grant) begin
          next_ptr   = grant_idx + 3'd1;
          next_cnt   = '0;
          next_state = found ? GRANT : IDLE;
        end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
          next_cnt = hold_cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output next-values; grant_idx keeps its last value when the arbiter goes idle.
  always_comb begin
    next_idx   = grant_idx;
    next_valid = grant_valid;
    next_new   = 1'b0;
    unique case (state)
      IDLE: begin
        next_valid = found;
        if (found) begin
          next_idx = winner;
          next_new = 1'b1;
        end
      end
      GRANT: begin
        if (end_grant) begin
          next_valid = found;
          if (found) begin
            next_idx = winner;
            next_new = 1'b1;
          end
        end
      end
      default: next_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rr_grant_index_8.sv
// Directed bench for rr_grant_index_8: a cycle-level model checked every cycle plus hand-computed grant checks.
module tb_rr_grant_index_8;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       release_grant;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       grant_new;

  int checks = 0;
  int passes = 0;

  rr_grant_index_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .release_grant(release_grant),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .grant_new(grant_new)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the grant, for how many cycles, and where the scan starts next.
  bit m_valid, m_new;
  int m_idx, m_ptr, m_age;

  function automatic int pick(input int start, input logic [7:0] r);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  w;
    bit  others, ending;
    if (!rst_n) begin
      m_valid = 0; m_new = 0; m_idx = 0; m_ptr = 0; m_age = 0;
    end else begin
      m_new = 0;
      if (!m_valid) begin
        w = pick(m_ptr, req);
        if (w >= 0) begin
          m_idx = w; m_valid = 1; m_new = 1; m_age = 0;
        end
      end else begin
        others = (req & ~(8'b1 << m_idx)) != 8'b0;
        ending = !req[m_idx] || (MAX_HOLD != 0 && m_age >= MAX_HOLD && others);
`ifdef ARB_LOCK_EN
        if (lock) ending = 0;
`endif
        ending = ending || release_grant;
        if (ending) begin
          m_ptr = (m_idx + 1) % 8;
          w = pick(m_ptr, req);
          if (w >= 0) begin
            m_idx = w; m_new = 1; m_age = 0;
          end else begin
            m_valid = 0;
          end
        end else begin
          m_age++;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (grant_valid === m_valid && grant_idx === 3'(m_idx) && grant_new === m_new)
      passes++;
    else
      $display("[TB] FAIL model t=%0t: got valid=%0b idx=%0d new=%0b, expected valid=%0b idx=%0d new=%0b",
               $time, grant_valid, grant_idx, grant_new, m_valid, m_idx, m_new);
  end

  task automatic applyStimulus(input logic [7:0] r, input logic rel);
    req = r;
    release_grant = rel;
    @(negedge clk);
    release_grant = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic v, input logic [2:0] idx, input logic n);
    checks++;
    if (grant_valid === v && grant_idx === idx && grant_new === n)
      passes++;
    else
      $display("[TB] FAIL %s: got valid=%0b idx=%0d new=%0b, expected valid=%0b idx=%0d new=%0b",
               name, grant_valid, grant_idx, grant_new, v, idx, n);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 8'h00;
    release_grant = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b0);
    checkOutput("idle", 1'b0, 3'd0, 1'b0);

    applyStimulus(8'h08, 1'b0);
    checkOutput("first_grant", 1'b1, 3'd3, 1'b1);
    @(negedge clk);
    checkOutput("first_grant_hold", 1'b1, 3'd3, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("drop_to_idle", 1'b0, 3'd3, 1'b0);

    // ptr now 4, so requester 7 wins first, then release alternates 0/7
    applyStimulus(8'h81, 1'b0);
    checkOutput("rr_start", 1'b1, 3'd7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(negedge clk);
      checkOutput("rr_hold", 1'b1, (k % 2 == 0) ? 3'd7 : 3'd0, 1'b0);
      applyStimulus(8'h81, 1'b1);
      checkOutput("rr_rotate", 1'b1, (k % 2 == 0) ? 3'd0 : 3'd7, 1'b1);
    end

    applyStimulus(8'h82, 1'b1);
    checkOutput("wrap", 1'b1, 3'd1, 1'b1);

    applyStimulus(8'h01, 1'b0);
    checkOutput("to_zero", 1'b1, 3'd0, 1'b1);
    applyStimulus(8'h05, 1'b0);
    repeat (14) @(negedge clk);
    checkOutput("timeout_last_hold", 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("timeout_rotate", 1'b1, 3'd2, 1'b1);

    applyStimulus(8'h01, 1'b0);
    checkOutput("solo_grant", 1'b1, 3'd0, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("solo_no_timeout", 1'b1, 3'd0, 1'b0);

    applyStimulus(8'h04, 1'b0);
    checkOutput("drop_regrant", 1'b1, 3'd2, 1'b1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("empty_idle", 1'b0, 3'd2, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkOutput("release_in_idle", 1'b0, 3'd2, 1'b0);

    applyStimulus(8'h20, 1'b0);
    checkOutput("grant5", 1'b1, 3'd5, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_reset", 1'b1, 3'd5, 1'b1);
    applyStimulus(8'h21, 1'b1);
    checkOutput("after_reset_wrap", 1'b1, 3'd0, 1'b1);

`ifdef ARB_LOCK_EN
    lock = 1'b1;
    applyStimulus(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("lock_hold", 1'b1, 3'd0, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkOutput("lock_release", 1'b0, 3'd0, 1'b0);
    lock = 1'b0;
`endif

    applyStimulus(8'h00, 1'b0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
